// File: rtl/onchip_ram_arb_pkg.sv
// Shared types and default sizing for the two-master on-chip RAM arbiter.
package onchip_ram_arb_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 10240;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic owner_t;

    function automatic state_t own_state(input owner_t o);
        return o ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/onchip_ram_arb_rr.sv
// Round-robin grant FSM with a bounded hold counter for two masters.
// IDLE costs one bubble; a forced handoff between owners does not.
module onchip_ram_arb_rr
    import onchip_ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_0,
    input  logic   req_1,
    input  logic   accept,
    output state_t state,
    output owner_t owner
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t     state_reg, state_next;
    owner_t     last_reg, last_next;
    logic [7:0] hold_reg, hold_next;
    owner_t     cur;
    logic       own_req;
    logic       oth_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        hold_next  = hold_reg;
        cur        = last_reg;
        own_req    = 1'b0;
        oth_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_next = '0;
                if (req_0 && req_1) begin
                    state_next = own_state(~last_reg);
                end else if (req_0) begin
                    state_next = OWN0;
                end else if (req_1) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                cur     = (state_reg == OWN1);
                own_req = cur ? req_1 : req_0;
                oth_req = cur ? req_0 : req_1;
                if (!own_req) begin
                    last_next  = cur;
                    hold_next  = '0;
                    state_next = oth_req ? own_state(~cur) : IDLE;
                end else if (accept) begin
                    // Counter parks at HOLD_MAX while alone so a newcomer waits at most one more transfer.
                    if (oth_req && hold_reg == HOLD_MAX) begin
                        state_next = own_state(~cur);
                        last_next  = cur;
                        hold_next  = '0;
                    end else if (hold_reg != HOLD_MAX) begin
                        hold_next = hold_reg + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state = state_reg;
    assign owner = (state_reg == OWN1);

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Optional address range check: define ONCHIP_RAM_ARB_RANGE_CHECK_EN.
module onchip_ram_arbiter
    import onchip_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,

    output logic                  range_err
);

    localparam int BE_W = DATA_W / 8;

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must be in 1..2**ADDR_W");
    end

    logic [ADDR_W-1:0] addr_arr  [2];
    logic [BE_W-1:0]   be_arr    [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [1:0]        rd_vec;
    logic [1:0]        wr_vec;
    logic [1:0]        req_vec;
    logic [1:0]        wait_vec;
    logic [1:0]        rvalid_vec;

    assign addr_arr[0]  = m0_address;
    assign addr_arr[1]  = m1_address;
    assign be_arr[0]    = m0_byteenable;
    assign be_arr[1]    = m1_byteenable;
    assign wdata_arr[0] = m0_writedata;
    assign wdata_arr[1] = m1_writedata;
    assign rd_vec       = {m1_read, m0_read};
    assign wr_vec       = {m1_write, m0_write};

    state_t state;
    owner_t owner;
    logic   accept;
    logic   acc_read;
    logic   sel_write;
    logic   ram_cs;

    onchip_ram_arb_rr #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req_0   (req_vec[0]),
        .req_1   (req_vec[1]),
        .accept  (accept),
        .state   (state),
        .owner   (owner)
    );

    // A simultaneous read+write is treated as a write; the read is dropped.
    assign sel_write = wr_vec[owner];
    assign accept    = (state != IDLE) && req_vec[owner];
    assign acc_read  = accept && !sel_write && rd_vec[owner];

    assign ram_address    = addr_arr[owner];
    assign ram_byteenable = be_arr[owner];
    assign ram_writedata  = wdata_arr[owner];
    assign ram_chipselect = ram_cs;
    assign ram_write      = ram_cs && sel_write;
    assign ram_clken      = 1'b1;

    logic   rd_pend_reg;
    owner_t rd_owner_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            rd_pend_reg <= acc_read;
            if (acc_read) begin
                rd_owner_reg <= owner;
            end
        end
    end

    logic [DATA_W-1:0] rdata;

`ifdef ONCHIP_RAM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic in_range;
    logic rd_oob_reg;
    logic range_err_reg;

    assign in_range = ({1'b0, ram_address} < DEPTH_LIM);
    assign ram_cs   = accept && in_range;

    // Out-of-range reads still complete, returning zero instead of RAM output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_oob_reg    <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            rd_oob_reg    <= acc_read && !in_range;
            range_err_reg <= range_err_reg || (accept && !in_range);
        end
    end

    assign rdata     = rd_oob_reg ? '0 : ram_readdata;
    assign range_err = range_err_reg;
`else
    assign ram_cs    = accept;
    assign rdata     = ram_readdata;
    assign range_err = 1'b0;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign req_vec[gi]    = rd_vec[gi] || wr_vec[gi];
        assign wait_vec[gi]   = (state != own_state(owner_t'(gi)));
        assign rvalid_vec[gi] = rd_pend_reg && (rd_owner_reg == owner_t'(gi));
    end

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rvalid_vec[0];
    assign m1_readdatavalid = rvalid_vec[1];
    assign m0_readdata      = rdata;
    assign m1_readdata      = rdata;

endmodule
